// File: rtl/bp_gshare.sv
`default_nettype none
// ============================================================================
//  Module      : bp_gshare
//  Description : Saturating-counter branch predictor, bimodal or gshare
//                indexed, with speculative/architectural global history
//                and always-on accuracy statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module bp_gshare #(
    parameter int XLEN   = 32,
    parameter int PHT_AW = 8,
    parameter int CTR_W  = 2,
    parameter int GHR_W  = 8,
    parameter int MODE   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             flush,
    input  logic [XLEN-1:0]  fet_pc,
    input  logic             fet_br,
    output logic             bp_pred,
    output logic [GHR_W-1:0] bp_ghr,
    input  logic             rob_bp_enable,
    input  logic [XLEN-1:0]  rob_bp_inst_addr,
    input  logic [GHR_W-1:0] rob_bp_ghr,
    input  logic             rob_bp_jump,
    input  logic             rob_bp_correct,
    output logic [XLEN-1:0]  bp_correct_cnt,
    output logic [XLEN-1:0]  bp_total_cnt
);

    localparam int               c_PHT_N    = 1 << PHT_AW;
    localparam logic [CTR_W-1:0] c_CTR_INIT = {1'b0, {(CTR_W-1){1'b1}}};
    localparam logic [CTR_W-1:0] c_CTR_MAX  = {CTR_W{1'b1}};

    function automatic logic [PHT_AW-1:0] f_idx(input logic [XLEN-1:0]  pc,
                                                 input logic [GHR_W-1:0] h);
        logic [PHT_AW-1:0] hx;
        hx = (MODE != 0) ? PHT_AW'(h) : {PHT_AW{1'b0}};
        return pc[PHT_AW:1] ^ hx;
    endfunction

    // Shift via a widened temporary so a 1-bit history needs no special case.
    function automatic logic [GHR_W-1:0] f_shift(input logic [GHR_W-1:0] h,
                                                 input logic             b);
        logic [GHR_W:0] t;
        t = {h, b};
        return t[GHR_W-1:0];
    endfunction

    logic [CTR_W-1:0]  r_pht [c_PHT_N];
    logic [GHR_W-1:0]  r_spec_ghr;
    logic [GHR_W-1:0]  r_arch_ghr;
    logic [XLEN-1:0]   r_correct;
    logic [XLEN-1:0]   r_total;

    logic [PHT_AW-1:0] w_fet_idx;
    logic [PHT_AW-1:0] w_cmt_idx;
    logic [CTR_W-1:0]  w_cmt_ctr;
    logic [CTR_W-1:0]  w_cmt_ctr_nxt;
    logic              w_fet_upd;
    logic              w_cmt_upd;
    logic              w_restore;
    logic              w_unused;

    assign w_fet_upd = rdy & ~flush & fet_br;
    assign w_cmt_upd = rdy & ~flush & rob_bp_enable;
    assign w_restore = rdy & flush;

    assign w_fet_idx = f_idx(fet_pc, r_spec_ghr);
    assign w_cmt_idx = f_idx(rob_bp_inst_addr, rob_bp_ghr);

    assign bp_pred        = r_pht[w_fet_idx][CTR_W-1];
    assign bp_ghr         = r_spec_ghr;
    assign bp_correct_cnt = r_correct;
    assign bp_total_cnt   = r_total;

    assign w_unused = ^{fet_pc[XLEN-1:PHT_AW+1], fet_pc[0],
                        rob_bp_inst_addr[XLEN-1:PHT_AW+1], rob_bp_inst_addr[0],
                        rob_bp_ghr};

    always_comb begin
        w_cmt_ctr     = r_pht[w_cmt_idx];
        w_cmt_ctr_nxt = w_cmt_ctr;
        if (rob_bp_jump) begin
            if (w_cmt_ctr != c_CTR_MAX) begin
                w_cmt_ctr_nxt = w_cmt_ctr + 1'b1;
            end
        end else if (w_cmt_ctr != '0) begin
            w_cmt_ctr_nxt = w_cmt_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < c_PHT_N; i++) begin
                r_pht[i] <= c_CTR_INIT;
            end
        end else if (w_cmt_upd) begin
            r_pht[w_cmt_idx] <= w_cmt_ctr_nxt;
        end
    end

    // Flush restores from the pre-commit architectural history; commits are
    // suppressed that cycle anyway, so the two never interact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spec_ghr <= '0;
            r_arch_ghr <= '0;
        end else begin
            if (w_restore) begin
                r_spec_ghr <= r_arch_ghr;
            end else if (w_fet_upd) begin
                r_spec_ghr <= f_shift(r_spec_ghr, bp_pred);
            end
            if (w_cmt_upd) begin
                r_arch_ghr <= f_shift(r_arch_ghr, rob_bp_jump);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_total   <= '0;
            r_correct <= '0;
        end else if (w_cmt_upd) begin
            r_total   <= r_total + 1'b1;
            r_correct <= r_correct + XLEN'(rob_bp_correct);
        end
    end

endmodule
`default_nettype wire

// File: doc/bp_gshare.md
# bp_gshare

Parametrised successor to the bimodal branch predictor: a table of saturating counters indexed either by PC alone (bimodal mode) or by PC XOR global branch history (gshare mode). It sits between the Fetcher, which reads a combinational prediction and pushes speculative history, and the ROB, which commits outcomes, trains the table and advances the architectural history. On flush, speculative history is restored from architectural history. Accuracy counters are always built, not debug-only.

## Interface
- XLEN, 32, data/address width and width of the statistics counters
- PHT_AW, 8, log2 of the table entry count; index uses pc[PHT_AW:1]
- CTR_W, 2, counter width (≥2)
- GHR_W, 8, global history length (1..PHT_AW)
- MODE, 1, 0 = bimodal (history ignored for indexing), 1 = gshare
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rdy  in  1  global enable; when low, all state holds
- flush  in  1  pipeline flush from ROB
- fet_pc  in  XLEN  PC being fetched
- fet_br  in  1  fetched instruction is a conditional branch; prediction consumed this cycle
- bp_pred  out  1  predicted taken for fet_pc
- bp_ghr  out  GHR_W  speculative history used for this prediction; Fetcher carries it to the ROB
- rob_bp_enable  in  1  a conditional branch commits this cycle
- rob_bp_inst_addr  in  XLEN  committed branch PC
- rob_bp_ghr  in  GHR_W  history snapshot carried with that branch
- rob_bp_jump  in  1  actual outcome taken
- rob_bp_correct  in  1  prediction was correct
- bp_correct_cnt  out  XLEN  committed correct predictions
- bp_total_cnt  out  XLEN  committed predictions

## Operation
- Index function: `idx(pc, h) = pc[PHT_AW:1] ^ (MODE ? zero-extended h : 0)`.
- Prediction: `bp_pred = MSB of pht[idx(fet_pc, spec_ghr)]`. `bp_ghr = spec_ghr`.
- Speculative history update: when rdy && !flush && fet_br, `spec_ghr <= {spec_ghr[GHR_W-2:0], bp_pred}`.
- Commit, when rdy && !flush && rob_bp_enable:
  - Entry `e = idx(rob_bp_inst_addr, rob_bp_ghr)`.
  - Counter at e: +1 if rob_bp_jump and not at all-ones; -1 if !rob_bp_jump and not at zero. Otherwise unchanged.
  - `arch_ghr <= {arch_ghr[GHR_W-2:0], rob_bp_jump}`.
  - `bp_total_cnt += 1`. `bp_correct_cnt += rob_bp_correct`. Both wrap modulo 2^XLEN.
- Flush, when rdy && flush:
  - `spec_ghr <= arch_ghr`, using its current value.
  - Any commit or fet_br in the same cycle is ignored: no table, history or counter change.
  - The ROB commits the mispredicting branch no later than the cycle before it raises flush.
- Reset, when rst_n is low, takes effect immediately regardless of clk and rdy:
  - Every counter is set to weakly not-taken, 2^(CTR_W-1)-1 (01 for CTR_W=2).
  - spec_ghr, arch_ghr and both statistics counters are cleared.
  - Reset asserted mid-operation discards all training.
- Reset values of outputs: bp_pred = 0, bp_ghr = 0, bp_correct_cnt = 0, bp_total_cnt = 0.
- Simultaneous events: fet_br and commit in the same cycle are independent.
  - If both touch the same entry, the prediction reads the pre-update value.
  - spec_ghr and arch_ghr update in parallel.

## Timing
- Prediction: zero latency, combinational from fet_pc and spec_ghr.
- Training: a commit is visible to predictions starting the next cycle.
- Speculative history: the shift from fet_br is visible to the next cycle's prediction.
- Flush: restoration of spec_ghr is visible the cycle after flush.
- rdy low: every register holds. Outputs still track fet_pc combinationally.
- No handshake, no backpressure: one prediction and one commit per cycle.

## Test plan
- Reset: hold rst_n=0, then release → bp_pred=0 for fet_pc=0x0 and 0x1FE; bp_ghr=0; both statistics counters 0. Assert rst_n low mid-run after training → counters revert immediately.
- Bimodal saturation (MODE=0, CTR_W=2): commit pc=0x100 taken ×3.
  - Counter goes 01→10→11→11; bp_pred at 0x100 becomes 1 from the cycle after the first commit.
  - Then commit not-taken ×4 → 11→10→01→00→00; bp_pred becomes 0 after the second not-taken.
- Gshare aliasing (MODE=1, GHR_W=8): train pc=0x100 taken with rob_bp_ghr=0x00 ×2.
  - Fetch 0x100 with spec_ghr=0x00 → pred 1.
  - Fetch 0x100 with spec_ghr=0x01 → pred 0, because it indexes a different entry.
- History and flush:
  - Three fet_br with bp_pred=1 → bp_ghr=0x07.
  - One commit with jump=0 → arch_ghr=0x00.
  - Flush → next cycle bp_ghr=0x00.
  - A commit asserted in the flush cycle leaves bp_total_cnt unchanged.
- Statistics: 5 commits with correct pattern 1,0,1,1,1 → bp_total_cnt=5, bp_correct_cnt=4. Preload total to 0xFFFFFFFF and commit once → wraps to 0.
- rdy gating: rdy=0 with fet_br and commit active for 4 cycles → no counter, history or statistics change. Set rdy=1 → updates resume on the next edge.
